// File: rtl/d1_multi_chan_fifo_pkg.sv
// rtl/d1_multi_chan_fifo_pkg.sv - shared width rules and pointer helpers for d1 FIFOs
package d1_fifo_pkg;

    localparam int PTR_MAX = 16;

    typedef logic [PTR_MAX-1:0] ptr_t;

    typedef struct packed {
        ptr_t wr;
        ptr_t rd;
    } ptr_pair_t;

    function automatic int PTR_W(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int CH_W(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

    function automatic int cnt_lsb(input int ch, input int depth);
        return ch * PTR_W(depth);
    endfunction

    // Increment keeping only the low pw bits, so the pointer rolls over at 2^pw.
    function automatic ptr_t ptr_inc(input ptr_t p, input int pw);
        ptr_t mask;
        mask = ptr_t'((32'd1 << pw) - 32'd1);
        return (p + ptr_t'(1)) & mask;
    endfunction

endpackage

// File: rtl/d1_multi_chan_fifo_if.sv
// rtl/d1_multi_chan_fifo_if.sv - push/pop/flag bundle for the multi-channel FIFO
interface d1_multi_chan_fifo_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 32,
    parameter int NCH   = 4
);
    localparam int CW = d1_fifo_pkg::CH_W(NCH);
    localparam int PW = d1_fifo_pkg::PTR_W(DEPTH);

    logic              push;
    logic [CW-1:0]     push_ch;
    logic [WIDTH-1:0]  wdata;
    logic              ack;
    logic              pop;
    logic [CW-1:0]     pop_ch;
    logic [NCH-1:0]    flush;
    logic              valid;
    logic [WIDTH-1:0]  rdata;
    logic [CW-1:0]     rd_ch;
    logic [NCH-1:0]    full;
    logic [NCH-1:0]    empty;
    logic [NCH-1:0]    al_full;
    logic [NCH-1:0]    al_empty;
    logic [NCH*PW-1:0] count;

    modport master (
        output push, push_ch, wdata, pop, pop_ch, flush,
        input  ack, valid, rdata, rd_ch, full, empty, al_full, al_empty, count
    );

    modport slave (
        input  push, push_ch, wdata, pop, pop_ch, flush,
        output ack, valid, rdata, rd_ch, full, empty, al_full, al_empty, count
    );

endinterface

// File: rtl/d1_multi_chan_fifo_dpram.sv
// rtl/d1_multi_chan_fifo_dpram.sv - simple dual-port memory, one-cycle registered read
module d1dpram #(
    parameter int WIDTH = 16,
    parameter int SIZE  = 128,
    parameter int SRAM  = 1
) (
    input  logic                    clk,
    input  logic                    wen,
    input  logic [$clog2(SIZE)-1:0] waddr,
    input  logic [WIDTH-1:0]        wdata,
    input  logic                    ren,
    input  logic [$clog2(SIZE)-1:0] raddr,
    output logic [WIDTH-1:0]        rdata
);
    logic [WIDTH-1:0] mem [SIZE];

    always_ff @(posedge clk) begin
        if (wen) mem[waddr] <= wdata;
    end

    generate
        if (SRAM != 0) begin : g_sram
            logic [WIDTH-1:0] rdata_q;
            always_ff @(posedge clk) begin
                if (ren) rdata_q <= mem[raddr];
            end
            assign rdata = rdata_q;
        end else begin : g_flop
            // Flop array: register the address and read the array behind it.
            logic [$clog2(SIZE)-1:0] raddr_q;
            always_ff @(posedge clk) begin
                if (ren) raddr_q <= raddr;
            end
            assign rdata = mem[raddr_q];
        end
    endgenerate

endmodule

// File: rtl/d1_multi_chan_fifo.sv
// rtl/d1_multi_chan_fifo.sv - NCH logical FIFOs sharing one dual-port memory
module d1_multi_chan_fifo
    import d1_fifo_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 32,
    parameter int NCH      = 4,
    parameter int SRAM     = 1,
    parameter int AL_FULL  = 2,
    parameter int AL_EMPTY = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    d1_multi_chan_fifo_if.slave      bus
);
    localparam int   L     = $clog2(DEPTH);
    localparam int   PW    = PTR_W(DEPTH);
    localparam int   CW    = CH_W(NCH);
    localparam int   AW    = CW + L;
    localparam ptr_t PMASK = ptr_t'((32'd1 << PW) - 32'd1);

    logic [NCH-1:0]   full_w, empty_w, al_full_w, al_empty_w;
    logic [L-1:0]     wr_idx [NCH];
    logic [L-1:0]     rd_idx [NCH];
    logic             push_ok, pop_ok;
    logic             valid_q;
    logic [CW-1:0]    rd_ch_q;
    logic [WIDTH-1:0] mem_rdata;

    assign push_ok = bus.push && !full_w[bus.push_ch]  && !bus.flush[bus.push_ch];
    assign pop_ok  = bus.pop  && !empty_w[bus.pop_ch]  && !bus.flush[bus.pop_ch];

    generate
        for (genvar c = 0; c < NCH; c++) begin : g_ch
            ptr_pair_t ptr_q;
            ptr_t      diff;
            logic      wr_hit, rd_hit;

            assign wr_hit = push_ok && (bus.push_ch == CW'(c));
            assign rd_hit = pop_ok  && (bus.pop_ch  == CW'(c));

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ptr_q <= '0;
                end else if (bus.flush[c]) begin
                    ptr_q <= '0;
                end else begin
                    if (wr_hit) ptr_q.wr <= ptr_inc(ptr_q.wr, PW);
                    if (rd_hit) ptr_q.rd <= ptr_inc(ptr_q.rd, PW);
                end
            end

            assign diff       = (ptr_q.wr - ptr_q.rd) & PMASK;
            assign wr_idx[c]  = ptr_q.wr[L-1:0];
            assign rd_idx[c]  = ptr_q.rd[L-1:0];
            assign empty_w[c] = (diff == '0);
            assign full_w[c]  = (diff == ptr_t'(DEPTH));
            assign bus.count[cnt_lsb(c, DEPTH) +: PW] = diff[PW-1:0];

            if (AL_FULL != 0) begin : g_alf
                assign al_full_w[c] = (diff >= ptr_t'(DEPTH - AL_FULL));
            end else begin : g_alf_off
                assign al_full_w[c] = 1'b0;
            end

            if (AL_EMPTY != 0) begin : g_ale
                assign al_empty_w[c] = (diff <= ptr_t'(AL_EMPTY));
            end else begin : g_ale_off
                assign al_empty_w[c] = 1'b0;
            end
        end
    endgenerate

    d1dpram #(
        .WIDTH (WIDTH),
        .SIZE  (NCH * DEPTH),
        .SRAM  (SRAM)
    ) u_mem (
        .clk   (clk),
        .wen   (push_ok),
        .waddr (AW'({bus.push_ch, wr_idx[bus.push_ch]})),
        .wdata (bus.wdata),
        .ren   (pop_ok),
        .raddr (AW'({bus.pop_ch, rd_idx[bus.pop_ch]})),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            rd_ch_q <= '0;
        end else begin
            valid_q <= pop_ok;
            if (pop_ok) rd_ch_q <= bus.pop_ch;
        end
    end

    assign bus.ack      = push_ok;
    assign bus.valid    = valid_q;
    assign bus.rdata    = valid_q ? mem_rdata : '0;
    assign bus.rd_ch    = valid_q ? rd_ch_q : '0;
    assign bus.full     = full_w;
    assign bus.empty    = empty_w;
    assign bus.al_full  = al_full_w;
    assign bus.al_empty = al_empty_w;

endmodule

// File: tb/tb_d1_multi_chan_fifo.sv
// tb/tb_d1_multi_chan_fifo.sv - scoreboard bench for d1_multi_chan_fifo
module tb_d1_multi_chan_fifo;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;
    localparam int NCH   = 4;

    typedef struct {
        logic [1:0]  ch;
        logic [15:0] data;
    } exp_t;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    logic [15:0] mq [NCH][$];
    exp_t        exp_q [$];

    d1_multi_chan_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NCH(NCH)) bus ();

    d1_multi_chan_fifo #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .NCH      (NCH),
        .SRAM     (1),
        .AL_FULL  (1),
        .AL_EMPTY (1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", tag, obs, exp);
        end
    endtask

    task automatic check_flags(input string tag);
        logic [11:0] ecnt;
        logic [3:0]  ee, ef, eaf, eae;
        for (int c = 0; c < NCH; c++) begin
            ecnt[c*3 +: 3] = 3'(mq[c].size());
            ee[c]  = (mq[c].size() == 0);
            ef[c]  = (mq[c].size() == DEPTH);
            eaf[c] = (mq[c].size() >= DEPTH - 1);
            eae[c] = (mq[c].size() <= 1);
        end
        check_eq({tag, ".count"},    32'(bus.count),    32'(ecnt));
        check_eq({tag, ".empty"},    32'(bus.empty),    32'(ee));
        check_eq({tag, ".full"},     32'(bus.full),     32'(ef));
        check_eq({tag, ".al_full"},  32'(bus.al_full),  32'(eaf));
        check_eq({tag, ".al_empty"}, 32'(bus.al_empty), 32'(eae));
    endtask

    // One clock: drive at posedge+1, check ack, advance model, check registered outputs.
    task automatic step(input string tag, input logic pu, input logic [1:0] pc, input logic [15:0] wd,
                        input logic po, input logic [1:0] oc, input logic [3:0] fl);
        logic pu_ok, po_ok;
        exp_t e;
        bus.push = pu; bus.push_ch = pc; bus.wdata = wd;
        bus.pop  = po; bus.pop_ch  = oc; bus.flush = fl;
        pu_ok = pu && (mq[pc].size() < DEPTH) && !fl[pc];
        po_ok = po && (mq[oc].size() > 0) && !fl[oc];
        #1;
        check_eq({tag, ".ack"}, 32'(bus.ack), 32'(pu_ok));
        if (po_ok) begin
            e.ch = oc;
            e.data = mq[oc].pop_front();
            exp_q.push_back(e);
        end
        if (pu_ok) mq[pc].push_back(wd);
        for (int c = 0; c < NCH; c++) if (fl[c]) mq[c].delete();
        @(posedge clk);
        #1;
        bus.push = 1'b0; bus.pop = 1'b0; bus.flush = '0;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_eq({tag, ".valid"}, 32'(bus.valid), 32'd1);
            check_eq({tag, ".rdata"}, 32'(bus.rdata), 32'(e.data));
            check_eq({tag, ".rd_ch"}, 32'(bus.rd_ch), 32'(e.ch));
        end else begin
            check_eq({tag, ".valid"}, 32'(bus.valid), 32'd0);
            check_eq({tag, ".rdata0"}, 32'(bus.rdata), 32'd0);
        end
        check_flags(tag);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.push = 1'b0; bus.push_ch = '0; bus.wdata = '0;
        bus.pop  = 1'b0; bus.pop_ch  = '0; bus.flush = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check_eq("rst.valid", 32'(bus.valid), 32'd0);
        check_flags("rst");
        step("pop_empty", 1'b0, 2'd0, 16'h0, 1'b1, 2'd0, 4'h0);

        for (int i = 0; i < 5; i++) step("fill2", 1'b1, 2'd2, 16'(16'h00A0 + i), 1'b0, 2'd0, 4'h0);
        for (int i = 0; i < 4; i++) step("drain2", 1'b0, 2'd0, 16'h0, 1'b1, 2'd2, 4'h0);

        for (int i = 0; i < 4; i++) begin
            step("il_p0", 1'b1, 2'd0, 16'(16'h1000 + i), 1'b0, 2'd0, 4'h0);
            step("il_p3", 1'b1, 2'd3, 16'(16'h3000 + i), 1'b0, 2'd0, 4'h0);
        end
        for (int i = 0; i < 4; i++) begin
            step("il_r0", 1'b0, 2'd0, 16'h0, 1'b1, 2'd0, 4'h0);
            step("il_r3", 1'b0, 2'd0, 16'h0, 1'b1, 2'd3, 4'h0);
        end

        step("s_p0", 1'b1, 2'd1, 16'h5100, 1'b0, 2'd0, 4'h0);
        step("s_p1", 1'b1, 2'd1, 16'h5101, 1'b0, 2'd0, 4'h0);
        step("same_c2", 1'b1, 2'd1, 16'h5102, 1'b1, 2'd1, 4'h0);
        step("s_p2", 1'b1, 2'd1, 16'h5103, 1'b0, 2'd0, 4'h0);
        step("s_p3", 1'b1, 2'd1, 16'h5104, 1'b0, 2'd0, 4'h0);
        step("same_c4", 1'b1, 2'd1, 16'h5105, 1'b1, 2'd1, 4'h0);
        for (int i = 0; i < 3; i++) step("s_dr", 1'b0, 2'd0, 16'h0, 1'b1, 2'd1, 4'h0);
        step("same_c0", 1'b1, 2'd1, 16'h5106, 1'b1, 2'd1, 4'h0);

        step("st_first", 1'b1, 2'd0, 16'h7000, 1'b0, 2'd0, 4'h0);
        for (int i = 1; i < 10; i++) step("stream", 1'b1, 2'd0, 16'(16'h7000 + i), 1'b1, 2'd0, 4'h0);
        step("st_last", 1'b0, 2'd0, 16'h0, 1'b1, 2'd0, 4'h0);

        step("f_p0", 1'b1, 2'd1, 16'h6100, 1'b0, 2'd0, 4'h0);
        step("f_p1", 1'b1, 2'd1, 16'h6101, 1'b0, 2'd0, 4'h0);
        step("flush_push", 1'b1, 2'd1, 16'h6102, 1'b0, 2'd0, 4'b0010);
        step("f_p2", 1'b1, 2'd1, 16'h6200, 1'b0, 2'd0, 4'h0);
        step("f_p3", 1'b1, 2'd1, 16'h6201, 1'b0, 2'd0, 4'h0);
        step("f_pop", 1'b0, 2'd0, 16'h0, 1'b1, 2'd1, 4'h0);
        step("flush_late", 1'b0, 2'd0, 16'h0, 1'b0, 2'd0, 4'b0010);

        step("r_p0", 1'b1, 2'd3, 16'h8300, 1'b0, 2'd0, 4'h0);
        step("r_p1", 1'b1, 2'd3, 16'h8301, 1'b0, 2'd0, 4'h0);
        bus.pop = 1'b1; bus.pop_ch = 2'd3;
        @(posedge clk);
        #1;
        bus.pop = 1'b0;
        rst_n = 1'b0;
        #1;
        for (int c = 0; c < NCH; c++) mq[c].delete();
        exp_q.delete();
        check_eq("mid_rst.valid", 32'(bus.valid), 32'd0);
        check_eq("mid_rst.rdata", 32'(bus.rdata), 32'd0);
        check_eq("mid_rst.rd_ch", 32'(bus.rd_ch), 32'd0);
        check_flags("mid_rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step("post_rst", 1'b0, 2'd0, 16'h0, 1'b1, 2'd3, 4'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
